mux_display_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-digit, 16-bit tick counter with multiplexed 7-segment output.
- A prescaler produces a tick every cycle+1 clocks, and each tick increments a CNT_WIDTH counter.
- The count is shown on DIGITS multiplexed 7-segment digits, in hex or decimal, with optional leading-zero blanking.
- Decimal conversion is a sequential shift-add-3 engine instead of a divider chain. A double-buffered display register guarantees the display never shows a partial conversion.

---
 rtl/mux_display_counter.sv | 209 ++++++++++++++++++++
 tb/tb_mux_display_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_display_counter.sv
// Prescaled event counter shown on multiplexed 7-segment digits (hex or decimal).
// Decimal uses a sequential shift-add-3 engine; the display buffer only loads finished results.
module mux_display_counter #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TICK_WIDTH = 32,
    parameter int unsigned SCAN_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hex,
    input  logic                  i_blank_lz,
    input  logic [TICK_WIDTH-1:0] i_cycle,
    input  logic [SCAN_WIDTH-1:0] i_segtiming,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_debug,
    output logic                  o_busy,
    output logic [DIGITS-1:0]     o_sel,
    output logic [7:0]            o_seg
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned ExtW = (BcdW > CNT_WIDTH) ? BcdW : CNT_WIDTH;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BitW = $clog2(CNT_WIDTH);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [TICK_WIDTH-1:0] r_presc;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_debug;
    logic                  r_hex;
    logic                  r_req;
    logic                  r_pend;
    logic [CNT_WIDTH-1:0]  r_snap;
    logic [BcdW-1:0]       r_bcd;
    logic [BitW-1:0]       r_bitcnt;
    logic [BcdW-1:0]       r_buf;
    logic [SCAN_WIDTH-1:0] r_scan;
    logic [IdxW-1:0]       r_idx;

    logic                  w_tick;
    logic                  w_want;
    logic                  w_last;
    logic                  w_snap_take;
    logic [BcdW-1:0]       w_bcd_adj;
    logic [BcdW-1:0]       w_bcd_next;
    logic [ExtW-1:0]       w_snap_ext;
    logic [DIGITS-1:0]     w_lead;
    logic                  w_seen;
    logic [3:0]            w_digit;
    logic                  w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign w_tick = (r_presc == i_cycle);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_count <= '0;
            r_debug <= 1'b0;
            r_hex   <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + TICK_WIDTH'(1);
            if (w_tick) begin
                r_count <= r_count + CNT_WIDTH'(1);
                r_debug <= ~r_debug;
            end
            r_hex <= i_hex;
            r_req <= w_tick | (i_hex != r_hex);
        end
    end

    assign w_want = r_req | r_pend;
    assign w_last = (r_bitcnt == BitW'(CNT_WIDTH - 1));
    // A finishing conversion with work queued snapshots immediately so the next one starts at once.
    assign w_snap_take = ((r_state == StIdle) && w_want) ||
                         ((r_state == StShift) && w_last && w_want);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_want) w_state_next = StLoad;
            StLoad:  w_state_next = r_hex ? StIdle : StShift;
            StShift: if (w_last) w_state_next = w_want ? StLoad : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy = (r_state == StShift);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= 1'b0;
        end else if (w_snap_take) begin
            r_pend <= 1'b0;
        end else if (r_req && (r_state != StIdle)) begin
            r_pend <= 1'b1;
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[BcdW-2:0], r_snap[CNT_WIDTH-1]};
    end

    assign w_snap_ext = ExtW'(r_snap);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_snap   <= '0;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            r_buf    <= '0;
        end else begin
            if (w_snap_take) begin
                r_snap <= r_count;
            end else if (r_state == StShift) begin
                r_snap <= r_snap << 1;
            end
            if (r_state == StLoad) begin
                if (r_hex) begin
                    r_buf <= w_snap_ext[BcdW-1:0];
                end else begin
                    r_bcd    <= '0;
                    r_bitcnt <= '0;
                end
            end else if (r_state == StShift) begin
                r_bcd    <= w_bcd_next;
                r_bitcnt <= r_bitcnt + BitW'(1);
                if (w_last) begin
                    r_buf <= w_bcd_next;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == i_segtiming) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
        end else begin
            r_scan <= r_scan + SCAN_WIDTH'(1);
        end
    end

    // w_lead[i] is set when digit i or any higher digit is non-zero.
    always_comb begin
        w_lead = '0;
        w_seen = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            w_seen    = w_seen | (r_buf[4*i +: 4] != 4'd0);
            w_lead[i] = w_seen;
        end
    end

    always_comb begin
        w_digit = r_buf[{r_idx, 2'b00} +: 4];
        w_blank = i_blank_lz && (r_idx != '0) && !w_lead[r_idx];
        o_seg   = w_blank ? 8'h00 : {1'b0, seg_decode(w_digit)};
        o_sel   = '0;
        o_sel[r_idx] = 1'b1;
    end

    assign o_count = r_count;
    assign o_debug = r_debug;

endmodule

// File: tb/tb_mux_display_counter.sv
// Directed bench for mux_display_counter at default parameters (4 digits, 16-bit count).
module tb_mux_display_counter;

    logic        clk;
    logic        rst;
    logic        hex;
    logic        blank_lz;
    logic [31:0] cycle;
    logic [7:0]  segtiming;
    logic [15:0] count;
    logic        debug;
    logic        busy;
    logic [3:0]  sel;
    logic [7:0]  seg;

    int n_checks;
    int n_fail;

    mux_display_counter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hex       (hex),
        .i_blank_lz  (blank_lz),
        .i_cycle     (cycle),
        .i_segtiming (segtiming),
        .o_count     (count),
        .o_debug     (debug),
        .o_busy      (busy),
        .o_sel       (sel),
        .o_seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after the last reset edge; digit index is 0 there.
    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check_digit(input string tag, input logic [3:0] exp_sel, input logic [7:0] exp_seg);
        check_eq({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    int busy_hi;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        hex       = 1'b0;
        blank_lz  = 1'b1;
        cycle     = 32'd1000;
        segtiming = 8'd0;

        // Reset state, blanking with an all-zero buffer
        do_reset();
        check_eq("rst_count", 32'(count), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_debug", 32'(debug), 32'h0);
        check_digit("rst_d0", 4'b0001, 8'h3F);
        step(1);
        check_digit("blank_zero_d1", 4'b0010, 8'h00);

        // Hex latency: tick at E4, snapshot E5, buffer E6 (index held at 0)
        blank_lz  = 1'b0;
        hex       = 1'b1;
        cycle     = 32'd3;
        segtiming = 8'd255;
        do_reset();
        step(4);
        check_eq("hex_tick_count", 32'(count), 32'h1);
        check_eq("hex_tick_debug", 32'(debug), 32'h1);
        step(1);
        check_digit("hex_lat_e5", 4'b0001, 8'h3F);
        check_eq("hex_lat_busy", 32'(busy), 32'h0);
        step(1);
        check_digit("hex_lat_e6", 4'b0001, 8'h06);

        // Hex scan: count 5 after 20 clocks, then freeze and walk the digits
        segtiming = 8'd0;
        do_reset();
        step(20);
        check_eq("hex_count5", 32'(count), 32'h5);
        cycle = 32'd1000;
        step(4);
        check_digit("scan_e24", 4'b0001, 8'h6D);
        step(1);
        check_digit("scan_e25", 4'b0010, 8'h3F);
        step(1);
        check_digit("scan_e26", 4'b0100, 8'h3F);
        step(1);
        check_digit("scan_e27", 4'b1000, 8'h3F);
        step(1);
        check_digit("scan_e28", 4'b0001, 8'h6D);

        // Decimal 1234: tick at E1294, busy E1296..E1311, buffer at E1312
        hex   = 1'b0;
        cycle = 32'd0;
        do_reset();
        step(1233);
        cycle = 32'd60;
        step(61);
        check_eq("dec_count1234", 32'(count), 32'd1234);
        step(1);
        check_eq("dec_busy_e1295", 32'(busy), 32'h0);
        busy_hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (busy) busy_hi++;
        end
        step(1);
        check_eq("dec_busy_len", 32'(busy_hi), 32'd16);
        check_eq("dec_busy_e1312", 32'(busy), 32'h0);
        check_digit("dec_d0", 4'b0001, 8'h66);
        step(1);
        check_digit("dec_d1", 4'b0010, 8'h4F);
        step(1);
        check_digit("dec_d2", 4'b0100, 8'h5B);
        step(1);
        check_digit("dec_d3", 4'b1000, 8'h06);

        // cycle=0 decimal: buffer 1 at E19, 18 at E36, 35 at E53
        cycle = 32'd0;
        do_reset();
        step(19);
        check_eq("pend_busy_e19", 32'(busy), 32'h0);
        step(1);
        check_eq("pend_busy_e20", 32'(busy), 32'h1);
        check_digit("pend_e20", 4'b0001, 8'h06);
        step(12);
        check_digit("pend_e32", 4'b0001, 8'h06);
        step(4);
        check_digit("pend_e36", 4'b0001, 8'h7F);
        step(16);
        check_digit("pend_e52", 4'b0001, 8'h7F);
        step(1);
        check_digit("pend_e53", 4'b0010, 8'h4F);
        step(3);
        check_digit("pend_e56", 4'b0001, 8'h6D);

        // Leading-zero blanking at count 7
        blank_lz = 1'b1;
        do_reset();
        step(7);
        cycle = 32'd1000;
        step(33);
        check_digit("blank7_d0", 4'b0001, 8'h07);
        step(1);
        check_digit("blank7_d1", 4'b0010, 8'h00);
        step(1);
        check_digit("blank7_d2", 4'b0100, 8'h00);
        step(1);
        check_digit("blank7_d3", 4'b1000, 8'h00);

        // Wrap: decimal 65535 shows 5535, hex shows FFFF, one tick wraps to 0
        blank_lz = 1'b0;
        cycle    = 32'd0;
        do_reset();
        step(65535);
        check_eq("wrap_countffff", 32'(count), 32'hFFFF);
        check_eq("wrap_debug1", 32'(debug), 32'h1);
        cycle = 32'd200;
        step(65);
        check_digit("wrap_dec_d0", 4'b0001, 8'h6D);
        step(1);
        check_digit("wrap_dec_d1", 4'b0010, 8'h4F);
        step(1);
        check_digit("wrap_dec_d2", 4'b0100, 8'h6D);
        step(1);
        check_digit("wrap_dec_d3", 4'b1000, 8'h6D);
        hex = 1'b1;
        step(5);
        check_digit("wrap_hex_d0", 4'b0001, 8'h71);
        step(3);
        check_digit("wrap_hex_d3", 4'b1000, 8'h71);
        step(124);
        check_eq("wrap_pre_tick", 32'(count), 32'hFFFF);
        step(1);
        check_eq("wrap_count0", 32'(count), 32'h0);
        check_eq("wrap_debug0", 32'(debug), 32'h0);
        step(1);
        check_digit("wrap_hex_old", 4'b0010, 8'h71);
        step(1);
        check_digit("wrap_hex_new", 4'b0100, 8'h3F);

        // Reset mid-conversion drops the result
        hex   = 1'b0;
        cycle = 32'd0;
        do_reset();
        step(5);
        check_eq("abort_busy_before", 32'(busy), 32'h1);
        rst   = 1'b1;
        cycle = 32'd1000;
        step(1);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_count", 32'(count), 32'h0);
        check_digit("abort_d0", 4'b0001, 8'h3F);
        step(20);
        check_eq("abort_busy_late", 32'(busy), 32'h0);
        check_digit("abort_late_d0", 4'b0001, 8'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
